// File: rtl/cpll_pkg.sv
// Shared definitions for the cpll clock-generator model: default parameters,
// lock FSM encoding and a constant-width helper.
package cpll_pkg;

  localparam int ACC_W_DEF       = 16;
  localparam int VID_INC_DEF     = 16384;
  localparam int LOCK_CYCLES_DEF = 1024;

  typedef enum logic {
    LS_WAIT,
    LS_LOCKED
  } lock_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpll_nco.sv
// Phase-accumulator NCO: adds INC every rising clk edge and registers the MSB of
// the new sum as the output clock.
module cpll_nco
  import cpll_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int INC   = VID_INC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic msb
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             msb_q;
  logic             msb_d;

  // Wrap-around modulo 2^ACC_W is intentional; the carry is discarded.
  always_comb begin
    acc_d = acc_q + ACC_W'(INC);
    msb_d = acc_d[ACC_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      msb_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      msb_q <= msb_d;
    end
  end

  assign msb = msb_q;

endmodule

// File: rtl/cpll.sv
// Digital model of the system PLL: NCO video clock c0, free copies c1/e0 of inclk0
// and a sticky locked flag. Optional output gating via CPLL_GATE_UNTIL_LOCK_EN.
module cpll
  import cpll_pkg::*;
#(
  parameter int ACC_W       = ACC_W_DEF,
  parameter int VID_INC     = VID_INC_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int E0_INVERT   = 1
) (
  input  logic inclk0,
  input  logic areset_n,
  output logic c0,
  output logic c1,
  output logic e0,
  output logic locked
);

  localparam int              CNT_W    = clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  lock_state_t      state_q;
  lock_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             locked_q;
  logic             locked_d;
  logic             c0_raw;
  logic             e0_raw;

  cpll_nco #(
    .ACC_W(ACC_W),
    .INC  (VID_INC)
  ) u_nco (
    .clk  (inclk0),
    .rst_n(areset_n),
    .msb  (c0_raw)
  );

  // The counter only advances while waiting, so it freezes once locked.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (state_q == LS_WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d  = LS_LOCKED;
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= LS_WAIT;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign e0_raw = (E0_INVERT != 0) ? ~inclk0 : inclk0;
  assign locked = locked_q;

`ifdef CPLL_GATE_UNTIL_LOCK_EN
  logic locked_n_q;
  logic locked_n_d;

  // Sampling lock on the falling edge lets the AND gates open while inclk0 is low,
  // so the first c1 pulse after lock is full width.
  assign locked_n_d = locked_q;

  always_ff @(negedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      locked_n_q <= 1'b0;
    end else begin
      locked_n_q <= locked_n_d;
    end
  end

  assign c0 = c0_raw & locked_n_q;
  assign c1 = inclk0 & locked_n_q;
  assign e0 = e0_raw & locked_n_q;
`else
  assign c0 = c0_raw;
  assign c1 = inclk0;
  assign e0 = e0_raw;
`endif

endmodule

// File: tb/tb_cpll.sv
// Self-checking bench for cpll: default instance (E0_INVERT=1) and a fractional
// instance (VID_INC=24330, E0_INVERT=0) share clock and reset.
module tb_cpll;

  localparam int LOCK  = 1024;
  localparam int INC_A = 16384;
  localparam int INC_B = 24330;
  localparam int W0    = 2048;
  localparam int NV    = 12;
`ifdef CPLL_GATE_UNTIL_LOCK_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  typedef struct {
    int   edge_i;
    logic exp_locked;
    logic exp_c0;
  } vec_t;

  logic inclk0   = 1'b0;
  logic areset_n = 1'b1;
  logic c0_a, c1_a, e0_a, locked_a;
  logic c0_b, c1_b, e0_b, locked_b;

  vec_t vecs[NV];
  vec_t sb[$];

  int   errors    = 0;
  int   checks    = 0;
  int   edge_n    = 0;
  int   vi        = 0;
  int   copy_err  = 0;
  int   c0_err    = 0;
  int   lock_err  = 0;
  int   per_err   = 0;
  int   rises     = 0;
  int   last_rise = 0;
  logic prev_b    = 1'b0;
  bit   frac_on   = 1'b0;

  always #5 inclk0 = ~inclk0;

  cpll #(
    .ACC_W(16), .VID_INC(INC_A), .LOCK_CYCLES(LOCK), .E0_INVERT(1)
  ) dut_a (
    .inclk0(inclk0), .areset_n(areset_n), .c0(c0_a), .c1(c1_a), .e0(e0_a), .locked(locked_a)
  );

  cpll #(
    .ACC_W(16), .VID_INC(INC_B), .LOCK_CYCLES(LOCK), .E0_INVERT(0)
  ) dut_b (
    .inclk0(inclk0), .areset_n(areset_n), .c0(c0_b), .c1(c1_b), .e0(e0_b), .locked(locked_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  // Ideal NCO output after n rising edges: MSB of (n*inc mod 2^16).
  function automatic logic nco_bit(input int n, input int inc);
    longint p;
    p = (longint'(n) * longint'(inc)) % 65536;
    return p[15];
  endfunction

  // Whether gated outputs are open at a sample taken in the high or low phase of edge n.
  function automatic logic gate_on(input int n, input logic high_phase);
    logic open;
    open = high_phase ? (n >= LOCK + 1) : (n >= LOCK);
    return !GATED || open;
  endfunction

  task automatic sample_high();
    logic g;
    vec_t v;
    g = gate_on(edge_n, 1'b1);
    if (c1_a !== g || c1_b !== g || e0_a !== 1'b0 || e0_b !== g) copy_err++;
    if (c0_a !== (nco_bit(edge_n, INC_A) & g) || c0_b !== (nco_bit(edge_n, INC_B) & g)) c0_err++;
    if (locked_a !== (edge_n >= LOCK) || locked_b !== (edge_n >= LOCK)) lock_err++;
    if (frac_on) begin
      if (edge_n == W0) begin
        prev_b = c0_b;
      end else if (edge_n > W0 && edge_n <= W0 + 65536) begin
        if (c0_b === 1'b1 && prev_b === 1'b0) begin
          rises++;
          if (last_rise > 0 && !((edge_n - last_rise) inside {2, 3})) per_err++;
          last_rise = edge_n;
        end
        prev_b = c0_b;
      end
    end
    if (sb.size() > 0) begin
      v = sb.pop_front();
      check("vec_locked", {31'd0, locked_a}, {31'd0, v.exp_locked});
      check("vec_c0", {31'd0, c0_a}, {31'd0, v.exp_c0});
    end
  endtask

  task automatic sample_low();
    logic g;
    g = gate_on(edge_n, 1'b0);
    if (c1_a !== 1'b0 || c1_b !== 1'b0 || e0_a !== g || e0_b !== 1'b0) copy_err++;
  endtask

  task automatic run_edges(input int n_edges);
    for (int k = 0; k < n_edges; k++) begin
      @(posedge inclk0);
      edge_n++;
      if (vi < NV && vecs[vi].edge_i == edge_n) begin
        sb.push_back(vecs[vi]);
        vi++;
      end
      #1;
      sample_high();
      @(negedge inclk0);
      #1;
      sample_low();
    end
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    repeat (5) @(posedge inclk0);
    #1;
    check("rst_locked_a", {31'd0, locked_a}, 32'd0);
    check("rst_locked_b", {31'd0, locked_b}, 32'd0);
    check("rst_c0_a", {31'd0, c0_a}, 32'd0);
    check("rst_c1_a", {31'd0, c1_a}, {31'd0, !GATED});
    check("rst_e0_b", {31'd0, e0_b}, {31'd0, !GATED});
    @(negedge inclk0);
    #1;
    areset_n = 1'b1;
    edge_n   = 0;
    vi       = 0;
  endtask

  initial begin
    int ev[NV];
    ev = '{1, 2, 3, 4, 5, 6, 7, 8, 1022, 1023, 1024, 1025};
    for (int i = 0; i < NV; i++) begin
      vecs[i].edge_i     = ev[i];
      vecs[i].exp_locked = (ev[i] >= LOCK);
      vecs[i].exp_c0     = nco_bit(ev[i], INC_A) & gate_on(ev[i], 1'b1);
    end

    // Lock timing, c0 waveforms and a full fractional period window
    #1;
    do_reset();
    frac_on = 1'b1;
    run_edges(W0 + 65536 + 4);
    frac_on = 1'b0;
    check("vectors_applied_1", vi, NV);
    check("frac_rises", rises, INC_B);
    check("frac_period_err", per_err, 0);

    // Mid-run 1-unit reset pulse while c0 is high
    do_reset();
    run_edges(3002);
    check("vectors_applied_2", vi, NV);
    check("pre_pulse_c0_a", {31'd0, c0_a}, 32'd1);
    check("pre_pulse_locked_a", {31'd0, locked_a}, 32'd1);
    areset_n = 1'b0;
    #1;
    check("pulse_locked_a", {31'd0, locked_a}, 32'd0);
    check("pulse_locked_b", {31'd0, locked_b}, 32'd0);
    check("pulse_c0_a", {31'd0, c0_a}, 32'd0);
    areset_n = 1'b1;
    edge_n   = 0;
    vi       = 0;
    run_edges(1030);
    check("vectors_applied_3", vi, NV);
    check("relock_a", {31'd0, locked_a}, 32'd1);

    check("copy_err", copy_err, 0);
    check("c0_err", c0_err, 0);
    check("lock_err", lock_err, 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
